// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel stage: two line buffers feed a 3x3 window, and |Gx|+|Gy| is packed
// into vga_controller write words {mag[10:7], addr[19:0]} with a fixed 3-cycle latency.
module sobel_stream #(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        sof,
    output logic [23:0] write_reg,
    output logic        write_valid,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [7:0]       r_lb0 [IMG_W];
    logic [7:0]       r_lb1 [IMG_W];
    logic [7:0]       r_p   [9];

    logic             r_s1_valid;
    logic             r_s1_last;
    logic [COL_W-1:0] r_s1_col;
    logic [ROW_W-1:0] r_s1_row;

    logic             r_s2_valid;
    logic             r_s2_last;
    logic signed [10:0] r_s2_gx;
    logic signed [10:0] r_s2_gy;
    logic [19:0]      r_s2_addr;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [7:0]       w_lb0;
    logic [7:0]       w_lb1;
    logic             w_out;
    logic             w_last;
    logic             w_busy_set;
    logic [10:0]      w_sx_pos;
    logic [10:0]      w_sx_neg;
    logic [10:0]      w_sy_pos;
    logic [10:0]      w_sy_neg;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [19:0]      w_addr;
    logic [10:0]      w_ax;
    logic [10:0]      w_ay;
    logic [10:0]      w_mag;
    logic [3:0]       w_data;

    // sof forces the accepted pixel to (0,0) regardless of counter state
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_lb0      = r_lb0[w_col];
    assign w_lb1      = r_lb1[w_col];
    assign w_out      = (w_col >= COL_TWO) && (w_row >= ROW_TWO);
    assign w_last     = (w_col == COL_LAST) && (w_row == ROW_LAST);
    assign w_busy_set = pix_valid && (w_col == '0) && (w_row == '0);

    always_comb begin
        w_sx_pos = 11'(r_p[2]) + {2'b00, r_p[5], 1'b0} + 11'(r_p[8]);
        w_sx_neg = 11'(r_p[0]) + {2'b00, r_p[3], 1'b0} + 11'(r_p[6]);
        w_sy_pos = 11'(r_p[6]) + {2'b00, r_p[7], 1'b0} + 11'(r_p[8]);
        w_sy_neg = 11'(r_p[0]) + {2'b00, r_p[1], 1'b0} + 11'(r_p[2]);
        w_gx     = w_sx_pos - w_sx_neg;
        w_gy     = w_sy_pos - w_sy_neg;
        w_addr   = (20'(r_s1_row) - 20'd1) * 20'(IMG_W) + 20'(r_s1_col) - 20'd1;
        w_ax     = r_s2_gx[10] ? 11'(-r_s2_gx) : r_s2_gx;
        w_ay     = r_s2_gy[10] ? 11'(-r_s2_gy) : r_s2_gy;
        w_mag    = w_ax + w_ay;
        w_data   = 4'(w_mag >> 7);
    end

    // Line buffers and window are data-only; rows 0-1 refill them before any output
    always_ff @(posedge clock) begin
        if (pix_valid) begin
            r_lb1[w_col] <= w_lb0;
            r_lb0[w_col] <= pix_in;
            r_p[0] <= r_p[1];
            r_p[1] <= r_p[2];
            r_p[2] <= w_lb1;
            r_p[3] <= r_p[4];
            r_p[4] <= r_p[5];
            r_p[5] <= w_lb0;
            r_p[6] <= r_p[7];
            r_p[7] <= r_p[8];
            r_p[8] <= pix_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col       <= '0;
            r_row       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
            r_s2_addr   <= '0;
            write_reg   <= '0;
            write_valid <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (pix_valid) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
            // Stage 1: window settles; remember which pixel enabled it
            r_s1_valid <= pix_valid && w_out;
            r_s1_last  <= pix_valid && w_out && w_last;
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            // Stage 2: gradients and address
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid && r_s1_last;
            r_s2_gx    <= w_gx;
            r_s2_gy    <= w_gy;
            r_s2_addr  <= w_addr;
            // Stage 3: magnitude and output word
            write_valid <= r_s2_valid;
            frame_done  <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                write_reg <= {w_data, r_s2_addr};
            end
            // A new frame start wins over the previous frame's completion
            busy <= w_busy_set || (busy && !(r_s2_valid && r_s2_last));
        end
    end

endmodule
